// File: rtl/receive_data_dispatch.sv
// Receive-side command dispatcher: decodes 1- and 2-byte UART frames
// into toggle-flagged command words for the machine FSMs.
module receive_data_dispatch #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [8:0]  op_cmd,
  output logic [8:0]  tgt_cmd,
  output logic [14:0] ext_cmd,
  output logic        cmd_stb,
  output logic        busy,
  output logic [7:0]  err_count,
  output logic [7:0]  leds
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXT  = 1'b1;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [5:0]      sid_q, sid_d;
  logic [8:0]      op_q, op_d;
  logic [8:0]      tgt_q, tgt_d;
  logic [14:0]     ext_q, ext_d;
  logic            stb_d, stb_q;
  logic [7:0]      err_q, err_d;
  logic [7:0]      leds_q, leds_d;
  logic            err_inc;

  // Frame decode, timeout tracking and next-state selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sid_d   = sid_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    ext_d   = ext_q;
    stb_d   = 1'b0;
    leds_d  = leds_q;
    err_inc = 1'b0;

    if (rx_valid) begin
      leds_d = rx_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (rx_data[7:6])
            2'b00: err_inc = (rx_data != 8'h00);
            2'b01: begin
              op_d  = {2'b00, rx_data[5:0], ~op_q[0]};
              stb_d = 1'b1;
            end
            2'b10: begin
              tgt_d = {2'b00, rx_data[5:0], ~tgt_q[0]};
              stb_d = 1'b1;
            end
            2'b11: begin
              sid_d   = rx_data[5:0];
              cnt_d   = '0;
              state_d = S_EXT;
            end
            default: ;
          endcase
        end
      end
      S_EXT: begin
        // A byte in the timeout cycle still completes the frame
        if (rx_valid) begin
          ext_d   = {sid_q, rx_data, ~ext_q[0]};
          stb_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sid_q   <= '0;
      op_q    <= '0;
      tgt_q   <= '0;
      ext_q   <= '0;
      stb_q   <= 1'b0;
      err_q   <= '0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sid_q   <= sid_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      ext_q   <= ext_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      leds_q  <= leds_d;
    end
  end

  assign op_cmd    = op_q;
  assign tgt_cmd   = tgt_q;
  assign ext_cmd   = ext_q;
  assign cmd_stb   = stb_q;
  assign busy      = (state_q == S_EXT);
  assign err_count = err_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_receive_data_dispatch.sv
// Directed plus random bench for receive_data_dispatch, checked
// against a frame-level reference model.
module tb_receive_data_dispatch;

  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [8:0]  op_cmd;
  logic [8:0]  tgt_cmd;
  logic [14:0] ext_cmd;
  logic        cmd_stb;
  logic        busy;
  logic [7:0]  err_count;
  logic [7:0]  leds;

  receive_data_dispatch #(
    .TIMEOUT_CYCLES(T),
    .TO_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .op_cmd(op_cmd),
    .tgt_cmd(tgt_cmd),
    .ext_cmd(ext_cmd),
    .cmd_stb(cmd_stb),
    .busy(busy),
    .err_count(err_count),
    .leds(leds)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: frame-level view
  bit          m_pend;
  logic [5:0]  m_sid;
  int          m_waited;
  logic [5:0]  m_op_data, m_tgt_data;
  bit          m_op_t, m_tgt_t, m_ext_t;
  logic [5:0]  m_ext_sid;
  logic [7:0]  m_ext_pay;
  int          m_err;
  logic [7:0]  m_leds;
  bit          m_stb;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".op"},  32'(op_cmd),  32'({2'b00, m_op_data, m_op_t}));
    chk({tag, ".tgt"}, 32'(tgt_cmd), 32'({2'b00, m_tgt_data, m_tgt_t}));
    chk({tag, ".ext"}, 32'(ext_cmd),
        32'({m_ext_sid, m_ext_pay, m_ext_t}));
    chk({tag, ".stb"},  32'(cmd_stb),   32'(m_stb));
    chk({tag, ".busy"}, 32'(busy),      32'(m_pend));
    chk({tag, ".err"},  32'(err_count), 32'(m_err));
    chk({tag, ".leds"}, 32'(leds),      32'(m_leds));
  endtask

  task automatic model_clear();
    m_pend = 0; m_sid = 0; m_waited = 0;
    m_op_data = 0; m_tgt_data = 0;
    m_op_t = 0; m_tgt_t = 0; m_ext_t = 0;
    m_ext_sid = 0; m_ext_pay = 0;
    m_err = 0; m_leds = 0; m_stb = 0;
  endtask

  task automatic add_err();
    if (m_err < 255) m_err = m_err + 1;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d);
    m_stb = 0;
    if (v) begin
      m_leds = d;
      if (m_pend) begin
        m_ext_sid = m_sid;
        m_ext_pay = d;
        m_ext_t   = !m_ext_t;
        m_stb     = 1;
        m_pend    = 0;
      end else if (d[7:6] == 2'd0) begin
        if (d != 8'h00) add_err();
      end else if (d[7:6] == 2'd1) begin
        m_op_data = d[5:0]; m_op_t = !m_op_t; m_stb = 1;
      end else if (d[7:6] == 2'd2) begin
        m_tgt_data = d[5:0]; m_tgt_t = !m_tgt_t; m_stb = 1;
      end else begin
        m_pend = 1; m_sid = d[5:0]; m_waited = 0;
      end
    end else if (m_pend) begin
      m_waited++;
      if (m_waited == T) begin
        m_pend = 0;
        add_err();
      end
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d,
                      input string tag, input bit do_chk = 1);
    rx_valid = v;
    rx_data  = v ? d : $urandom_range(0, 255);
    @(posedge clk);
    #1;
    rx_valid = 0;
    model_step(v, d);
    if (do_chk) check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 8'h00, tag);
  endtask

  task automatic do_reset();
    rst = 1; rx_valid = 0; rx_data = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    check_all("reset");
  endtask

  initial begin
    rst = 1; rx_valid = 0; rx_data = 0;
    model_clear();
    do_reset();

    // 1: single operate command
    step(1, 8'h45, "t1_op");
    chk("t1_op_word", 32'(op_cmd), 32'h00B);
    idle(1, "t1_stb_low");

    // 2: repeated identical command toggles again
    step(1, 8'h45, "t2_a");
    chk("t2_tog0", 32'(op_cmd), 32'h00A);
    step(1, 8'h45, "t2_b");
    chk("t2_tog1", 32'(op_cmd), 32'h00B);
    idle(1, "t2_idle");

    // 3: extended frame with gap
    step(1, 8'hC3, "t3_hdr");
    idle(10, "t3_wait");
    step(1, 8'h7F, "t3_pay");
    chk("t3_ext", 32'(ext_cmd), 32'({6'h03, 8'h7F, 1'b1}));
    idle(1, "t3_idle");

    // 4: timeout drops frame
    step(1, 8'hC3, "t4_hdr");
    idle(T, "t4_wait");
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_err", 32'(err_count), 32'd1);

    // payload in the timeout cycle still wins
    step(1, 8'hC5, "tb_hdr");
    idle(T - 1, "tb_wait");
    step(1, 8'h00, "tb_pay");
    chk("tb_noerr", 32'(err_count), 32'd1);

    // back-to-back bytes
    step(1, 8'h41, "bb0");
    step(1, 8'h82, "bb1");
    step(1, 8'hFF, "bb2");
    step(1, 8'hC0, "bb3");
    idle(1, "bb_idle");

    // 5: idle byte, error byte, saturation
    step(1, 8'h00, "t5_idle");
    step(1, 8'h15, "t5_err");
    for (int i = 0; i < 300; i++)
      step(1, 8'($urandom_range(1, 63)), "t5_sat", 0);
    check_all("t5_sat");
    chk("t5_255", 32'(err_count), 32'd255);

    // 6: reset mid-frame
    do_reset();
    step(1, 8'hC1, "t6_hdr");
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    check_all("t6_rst");
    step(1, 8'h22, "t6_after");
    idle(2, "t6_idle");

    // random traffic with occasional long gaps
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        idle(T + 5, "rnd_gap");
      else
        step($urandom_range(0, 99) < 40,
             8'($urandom_range(0, 255)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
